// File: rtl/dut_req_arbiter_if.sv
// Request/output bundle between N requesters, the arbiter and the downstream dut slave port.
// Requester i occupies slice [i*W +: W] of each packed req_* vector.
interface dut_req_arbiter_if #(
  parameter int N      = 4,
  parameter int CMD_W  = 2,
  parameter int ADR_W  = 3,
  parameter int DATA_W = 3
);
  localparam int SRC_W = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]        req_valid;
  logic [N-1:0]        req_lock;
  logic [N*CMD_W-1:0]  req_cmd;
  logic [N*ADR_W-1:0]  req_adr;
  logic [N*DATA_W-1:0] req_data;
  logic [N-1:0]        req_ready;
  logic                m_valid;
  logic                m_ready;
  logic [CMD_W-1:0]    m_cmd;
  logic [ADR_W-1:0]    m_adr;
  logic [DATA_W-1:0]   m_data;
  logic [SRC_W-1:0]    m_src;

  modport slave (
    input  req_valid, req_lock, req_cmd, req_adr, req_data, m_ready,
    output req_ready, m_valid, m_cmd, m_adr, m_data, m_src
  );

  modport master (
    output req_valid, req_lock, req_cmd, req_adr, req_data, m_ready,
    input  req_ready, m_valid, m_cmd, m_adr, m_data, m_src
  );
endinterface

// File: rtl/dut_req_arbiter.sv
// Round-robin arbiter with locked bursts into a single registered output stage; NOP beats are
// consumed without forwarding. Latency 1 cycle; req_ready only while the output stage can load.
module dut_req_arbiter #(
  parameter int N         = 4,
  parameter int CMD_W     = 2,
  parameter int ADR_W     = 3,
  parameter int DATA_W    = 3,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  dut_req_arbiter_if.slave  arb_if
);
  localparam int SRC_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {ST_ARB, ST_LOCKED} state_t;

  state_t            state_q, state_d;
  logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [SRC_W-1:0]  owner_q, owner_d;
  logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic              m_valid_q, m_valid_d;
  logic [CMD_W-1:0]  m_cmd_q, m_cmd_d;
  logic [ADR_W-1:0]  m_adr_q, m_adr_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [SRC_W-1:0]  m_src_q, m_src_d;

  logic              load_en;
  logic              scan_vld;
  logic [SRC_W-1:0]  scan_idx;
  logic [SRC_W-1:0]  scan_try;
  logic              sel_vld;
  logic [SRC_W-1:0]  sel;
  logic [N-1:0]      ready_vec;
  logic [CMD_W-1:0]  sel_cmd;
  logic [ADR_W-1:0]  sel_adr;
  logic [DATA_W-1:0] sel_data;
  logic [CNT_W-1:0]  new_cnt;

  assign load_en = !m_valid_q || arb_if.m_ready;

  // First valid requester after the last grant, wrapping modulo N.
  always_comb begin
    scan_vld = 1'b0;
    scan_idx = rr_ptr_q;
    scan_try = rr_ptr_q;
    for (int k = 1; k <= N; k++) begin
      scan_try = SRC_W'((int'(rr_ptr_q) + k) % N);
      if (!scan_vld && arb_if.req_valid[scan_try]) begin
        scan_vld = 1'b1;
        scan_idx = scan_try;
      end
    end
  end

  // A locked owner keeps priority only while it still presents a beat.
  always_comb begin
    sel     = scan_idx;
    sel_vld = load_en && scan_vld;
    if (state_q == ST_LOCKED && arb_if.req_valid[owner_q]) begin
      sel     = owner_q;
      sel_vld = load_en;
    end
  end

  always_comb begin
    ready_vec = '0;
    for (int i = 0; i < N; i++) begin
      ready_vec[i] = sel_vld && (sel == SRC_W'(i));
    end
  end

  assign sel_cmd  = arb_if.req_cmd[int'(sel)*CMD_W +: CMD_W];
  assign sel_adr  = arb_if.req_adr[int'(sel)*ADR_W +: ADR_W];
  assign sel_data = arb_if.req_data[int'(sel)*DATA_W +: DATA_W];

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    m_valid_d   = m_valid_q;
    m_cmd_d     = m_cmd_q;
    m_adr_d     = m_adr_q;
    m_data_d    = m_data_q;
    m_src_d     = m_src_q;
    new_cnt     = CNT_W'(1);
    if (sel_vld) begin
      // LOCKED implies burst_cnt_q < MAX_BURST, so the increment cannot wrap.
      if (state_q == ST_LOCKED && sel == owner_q) begin
        new_cnt = burst_cnt_q + CNT_W'(1);
      end
      rr_ptr_d    = sel;
      owner_d     = sel;
      burst_cnt_d = new_cnt;
      state_d     = (arb_if.req_lock[sel] && new_cnt < CNT_W'(MAX_BURST)) ? ST_LOCKED : ST_ARB;
      if (sel_cmd != '0) begin
        m_valid_d = 1'b1;
        m_cmd_d   = sel_cmd;
        m_adr_d   = sel_adr;
        m_data_d  = sel_data;
        m_src_d   = sel;
      end else if (arb_if.m_ready) begin
        m_valid_d = 1'b0;
      end
    end else if (arb_if.m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ARB;
      rr_ptr_q    <= SRC_W'(N - 1);
      owner_q     <= '0;
      burst_cnt_q <= '0;
      m_valid_q   <= 1'b0;
      m_cmd_q     <= '0;
      m_adr_q     <= '0;
      m_data_q    <= '0;
      m_src_q     <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      m_valid_q   <= m_valid_d;
      m_cmd_q     <= m_cmd_d;
      m_adr_q     <= m_adr_d;
      m_data_q    <= m_data_d;
      m_src_q     <= m_src_d;
    end
  end

  assign arb_if.req_ready = ready_vec;
  assign arb_if.m_valid   = m_valid_q;
  assign arb_if.m_cmd     = m_cmd_q;
  assign arb_if.m_adr     = m_adr_q;
  assign arb_if.m_data    = m_data_q;
  assign arb_if.m_src     = m_src_q;
endmodule

// File: tb/tb_dut_req_arbiter.sv
// Bench for dut_req_arbiter: constant vector table, corner-case sequences, and random traffic
// checked against an integer-level model of the arbitration rules.
module tb_dut_req_arbiter;
  localparam int NREQ = 4;
  localparam int CW   = 2;
  localparam int AW   = 3;
  localparam int DW   = 3;
  localparam int MAXB = 4;

  logic clk;
  logic rst_n;

  dut_req_arbiter_if #(.N(NREQ), .CMD_W(CW), .ADR_W(AW), .DATA_W(DW)) bus ();

  dut_req_arbiter #(.N(NREQ), .CMD_W(CW), .ADR_W(AW), .DATA_W(DW), .MAX_BURST(MAXB)) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .arb_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Model state: lk_own = -1 when no burst is in progress.
  int mv, mcmd, madr, mdata, msrc, last_g, lk_own, bcnt;
  logic [3:0] smp_ready;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] lock;
    logic [7:0] cmd;
    logic       mr;
    logic [3:0] rdy;
    logic       mv;
    logic [1:0] src;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int field(input int vec, input int idx, input int w);
    return (vec >> (idx * w)) & ((1 << w) - 1);
  endfunction

  function automatic int pick();
    if (mv != 0 && !bus.m_ready) return -1;
    if (lk_own >= 0 && bus.req_valid[lk_own]) return lk_own;
    for (int k = 1; k <= NREQ; k++) begin
      int i = (last_g + k) % NREQ;
      if (bus.req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    mv = 0; mcmd = 0; madr = 0; mdata = 0; msrc = 0;
    last_g = NREQ - 1; lk_own = -1; bcnt = 0;
  endtask

  task automatic model_advance(input int s);
    if (s >= 0) begin
      int c = field(int'(bus.req_cmd), s, CW);
      if (c != 0) begin
        mv = 1; mcmd = c; msrc = s;
        madr  = field(int'(bus.req_adr), s, AW);
        mdata = field(int'(bus.req_data), s, DW);
      end else if (bus.m_ready) begin
        mv = 0;
      end
      last_g = s;
      if (s == lk_own) bcnt++;
      else bcnt = 1;
      lk_own = (bus.req_lock[s] && bcnt < MAXB) ? s : -1;
    end else if (bus.m_ready) begin
      mv = 0;
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic [7:0] c,
                       input logic [11:0] a, input logic [11:0] d, input logic mr);
    bus.req_valid = v;
    bus.req_lock  = l;
    bus.req_cmd   = c;
    bus.req_adr   = a;
    bus.req_data  = d;
    bus.m_ready   = mr;
  endtask

  // One clock: check ready before the edge, then the registered outputs after it.
  task automatic tick();
    int s;
    logic [3:0] er;
    #2;
    s  = pick();
    er = (s >= 0) ? (4'b0001 << s) : 4'b0000;
    smp_ready = bus.req_ready;
    chk("req_ready", int'(smp_ready), int'(er));
    @(posedge clk);
    #1;
    model_advance(s);
    chk("m_valid", int'(bus.m_valid), mv);
    chk("m_cmd",   int'(bus.m_cmd),   mcmd);
    chk("m_adr",   int'(bus.m_adr),   madr);
    chk("m_data",  int'(bus.m_data),  mdata);
    chk("m_src",   int'(bus.m_src),   msrc);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(4'h0, 4'h0, 8'h00, 12'h000, 12'h000, 1'b0);
    model_reset();
    #2;
    chk("rst_m_valid_async", int'(bus.m_valid), 0);
    @(posedge clk);
    #1;
    chk("rst_m_valid", int'(bus.m_valid), 0);
    chk("rst_m_src",   int'(bus.m_src),   0);
    chk("rst_m_cmd",   int'(bus.m_cmd),   0);
    chk("rst_ready",   int'(bus.req_ready), 0);
    rst_n = 1'b1;
  endtask

  initial begin
    int exp2[6];
    rst_n = 1'b1;
    drive(4'h0, 4'h0, 8'h00, 12'h000, 12'h000, 1'b0);
    model_reset();

    //          valid  lock   cmd    mr    rdy    mv    src
    tbl[0]  = '{4'hf, 4'h0, 8'haa, 1'b1, 4'h1, 1'b1, 2'd0};
    tbl[1]  = '{4'hf, 4'h0, 8'haa, 1'b1, 4'h2, 1'b1, 2'd1};
    tbl[2]  = '{4'hf, 4'h0, 8'haa, 1'b1, 4'h4, 1'b1, 2'd2};
    tbl[3]  = '{4'hf, 4'h0, 8'haa, 1'b1, 4'h8, 1'b1, 2'd3};
    tbl[4]  = '{4'hf, 4'h0, 8'haa, 1'b1, 4'h1, 1'b1, 2'd0};
    tbl[5]  = '{4'hf, 4'h0, 8'haa, 1'b0, 4'h0, 1'b1, 2'd0};
    tbl[6]  = '{4'hf, 4'h0, 8'haa, 1'b0, 4'h0, 1'b1, 2'd0};
    tbl[7]  = '{4'hf, 4'h0, 8'haa, 1'b1, 4'h2, 1'b1, 2'd1};
    tbl[8]  = '{4'h0, 4'h0, 8'haa, 1'b1, 4'h0, 1'b0, 2'd1};
    tbl[9]  = '{4'h4, 4'h4, 8'haa, 1'b1, 4'h4, 1'b1, 2'd2};
    tbl[10] = '{4'hf, 4'h4, 8'haa, 1'b1, 4'h4, 1'b1, 2'd2};
    tbl[11] = '{4'hf, 4'h4, 8'haa, 1'b1, 4'h4, 1'b1, 2'd2};
    tbl[12] = '{4'hf, 4'h4, 8'haa, 1'b1, 4'h4, 1'b1, 2'd2};
    tbl[13] = '{4'hf, 4'h4, 8'haa, 1'b1, 4'h8, 1'b1, 2'd3};

    do_reset();

    // Requester i carries adr=i, data=i so the output fields identify the source.
    for (int t = 0; t < 14; t++) begin
      drive(tbl[t].valid, tbl[t].lock, tbl[t].cmd, 12'h688, 12'h688, tbl[t].mr);
      tick();
      chk($sformatf("tbl%0d_ready", t), int'(smp_ready),   int'(tbl[t].rdy));
      chk($sformatf("tbl%0d_valid", t), int'(bus.m_valid), int'(tbl[t].mv));
      chk($sformatf("tbl%0d_src", t),   int'(bus.m_src),   int'(tbl[t].src));
      chk($sformatf("tbl%0d_adr", t),   int'(bus.m_adr),   int'(tbl[t].src));
    end

    // Locked burst of requester 1 capped at MAX_BURST, then round-robin resumes.
    do_reset();
    drive(4'h1, 4'h0, 8'haa, 12'h688, 12'h688, 1'b1);
    tick();
    exp2 = '{1, 1, 1, 1, 2, 0};
    drive(4'h7, 4'h2, 8'haa, 12'h688, 12'h688, 1'b1);
    for (int t = 0; t < 6; t++) begin
      tick();
      chk($sformatf("burst_src%0d", t), int'(bus.m_src), exp2[t]);
    end

    // Downstream stall: held beat stays put and nothing is accepted.
    do_reset();
    drive(4'h1, 4'h0, 8'h02, 12'h003, 12'h005, 1'b1);
    tick();
    drive(4'h2, 4'h0, 8'h08, 12'h008, 12'h010, 1'b0);
    for (int t = 0; t < 5; t++) begin
      tick();
      chk("stall_ready", int'(smp_ready), 0);
      chk("stall_adr", int'(bus.m_adr), 3);
      chk("stall_data", int'(bus.m_data), 5);
    end
    bus.m_ready = 1'b1;
    tick();
    chk("drain_src", int'(bus.m_src), 1);
    chk("drain_data", int'(bus.m_data), 2);

    // NOP beat consumed without output, real beat follows one cycle later.
    do_reset();
    drive(4'h4, 4'h0, 8'h00, 12'h000, 12'h000, 1'b1);
    tick();
    chk("nop_ready", int'(smp_ready), 4);
    chk("nop_valid", int'(bus.m_valid), 0);
    drive(4'h4, 4'h0, 8'h20, 12'h100, 12'h000, 1'b1);
    tick();
    chk("post_nop_valid", int'(bus.m_valid), 1);
    chk("post_nop_adr", int'(bus.m_adr), 4);
    chk("post_nop_src", int'(bus.m_src), 2);

    // Lock owner drops valid: lock is abandoned, scan continues from the new grant.
    do_reset();
    drive(4'h3, 4'h1, 8'haa, 12'h688, 12'h688, 1'b1);
    tick();
    drive(4'h2, 4'h0, 8'haa, 12'h688, 12'h688, 1'b1);
    tick();
    chk("abandon_src", int'(bus.m_src), 1);
    drive(4'h7, 4'h0, 8'haa, 12'h688, 12'h688, 1'b1);
    tick();
    chk("abandon_next_src", int'(bus.m_src), 2);

    // Asynchronous reset while a locked beat is stalled in the output stage.
    do_reset();
    drive(4'h1, 4'h1, 8'haa, 12'h688, 12'h688, 1'b1);
    tick();
    bus.m_ready = 1'b0;
    tick();
    chk("pre_rst_valid", int'(bus.m_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", int'(bus.m_valid), 0);
    chk("midrst_src", int'(bus.m_src), 0);
    drive(4'h0, 4'h0, 8'h00, 12'h000, 12'h000, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(4'hf, 4'h0, 8'haa, 12'h688, 12'h688, 1'b1);
    tick();
    chk("post_rst_src", int'(bus.m_src), 0);

    // Random traffic against the model.
    do_reset();
    for (int t = 0; t < 1500; t++) begin
      drive(4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15) | (($urandom_range(0, 1) != 0) ? 15 : 0)),
            8'($urandom), 12'($urandom), 12'($urandom),
            ($urandom_range(0, 3) != 0));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
